// File: rtl/sistema_cpu1_ocimem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : sistema_cpu1_ocimem_arbiter_if
// Description : Bus bundle for the OCI memory arbiter. It carries the JTAG
//               side request/response, the Avalon debug_mem_slave port and
//               the OCI RAM port. The arbiter connects through the slave
//               modport. The surrounding system (JTAG logic, Avalon fabric
//               and RAM) connects through the master modport.
// Ports       : debugack, jtag_* (req/wr/addr/wdata/done/rdata),
//               av_* (read/write/address/writedata/byteenable/
//               waitrequest/readdata), ram_* (addr/wren/byteen/wdata/rdata)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface sistema_cpu1_ocimem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              debugack;

  logic              jtag_req;
  logic              jtag_wr;
  logic [ADDR_W-1:0] jtag_addr;
  logic [31:0]       jtag_wdata;
  logic              jtag_done;
  logic [31:0]       jtag_rdata;

  logic              av_read;
  logic              av_write;
  logic [ADDR_W-1:0] av_address;
  logic [31:0]       av_writedata;
  logic [3:0]        av_byteenable;
  logic              av_waitrequest;
  logic [31:0]       av_readdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [3:0]        ram_byteen;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  debugack,
    input  jtag_req, jtag_wr, jtag_addr, jtag_wdata,
    output jtag_done, jtag_rdata,
    input  av_read, av_write, av_address, av_writedata, av_byteenable,
    output av_waitrequest, av_readdata,
    output ram_addr, ram_wren, ram_byteen, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output debugack,
    output jtag_req, jtag_wr, jtag_addr, jtag_wdata,
    input  jtag_done, jtag_rdata,
    output av_read, av_write, av_address, av_writedata, av_byteenable,
    input  av_waitrequest, av_readdata,
    input  ram_addr, ram_wren, ram_byteen, ram_wdata,
    output ram_rdata
  );
endinterface

`default_nettype wire

// File: rtl/sistema_cpu1_ocimem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : sistema_cpu1_ocimem_arbiter
// Description : Arbitrates the single-port OCI RAM between the JTAG debug path
//               and the Avalon debug_mem_slave. While the CPU is in debug mode,
//               JTAG has strict priority. Otherwise the two requesters are
//               served round-robin. The arbiter completes one access at a time:
//               a write takes one cycle after the grant, and a read takes three
//               because the RAM has one cycle of registered read latency.
// Ports       : clk     - clock, rising edge
//               reset_n - asynchronous active-low reset
//               bus     - sistema_cpu1_ocimem_arbiter_if.slave (JTAG, Avalon
//                         and RAM signals)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sistema_cpu1_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input wire clk,
  input wire reset_n,
  sistema_cpu1_ocimem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RWAIT  = 2'd2,
    ST_RDONE  = 2'd3
  } state_t;

  localparam logic SRC_JTAG = 1'b0;
  localparam logic SRC_AV   = 1'b1;

  state_t            r_state;
  state_t            w_next;
  logic              r_last_grant;
  logic              r_win;
  logic              r_is_wr;

  logic              w_jtag_pend;
  logic              w_av_pend;
  logic              w_win;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic [3:0]        w_sel_be;
  logic              w_grant;
  logic              w_complete;
  logic              w_capture;

  // Pick the winner and mux its request fields. The result is used only in IDLE.
  always_comb begin
    w_jtag_pend = bus.jtag_req;
    w_av_pend   = bus.av_read | bus.av_write;
    w_win       = SRC_JTAG;
    if (w_jtag_pend && w_av_pend) begin
      if (bus.debugack) begin
        w_win = SRC_JTAG;
      end else begin
        // On a tie, the side that was not granted last time wins.
        w_win = (r_last_grant == SRC_AV) ? SRC_JTAG : SRC_AV;
      end
    end else if (w_av_pend) begin
      w_win = SRC_AV;
    end

    if (w_win == SRC_JTAG) begin
      w_sel_wr    = bus.jtag_wr;
      w_sel_addr  = bus.jtag_addr;
      w_sel_wdata = bus.jtag_wdata;
      w_sel_be    = 4'hF;
    end else begin
      w_sel_wr    = bus.av_write;
      w_sel_addr  = bus.av_address;
      w_sel_wdata = bus.av_writedata;
      w_sel_be    = bus.av_byteenable;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_complete = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_jtag_pend || w_av_pend) begin
          w_grant = 1'b1;
          w_next  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (r_is_wr) begin
          w_complete = 1'b1;
          w_next     = ST_IDLE;
        end else begin
          w_next = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        // The RAM registered the read address at the end of ACCESS.
        w_capture = 1'b1;
        w_next    = ST_RDONE;
      end
      ST_RDONE: begin
        w_complete = 1'b1;
        w_next     = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Completion and write strobes are decoded from the registered state.
  // This keeps them at zero and one during reset without any extra logic.
  assign bus.jtag_done      = w_complete && (r_win == SRC_JTAG);
  assign bus.av_waitrequest = !(w_complete && (r_win == SRC_AV));
  assign bus.ram_wren       = (r_state == ST_ACCESS) && r_is_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant    <= SRC_AV;
      r_win           <= SRC_JTAG;
      r_is_wr         <= 1'b0;
      bus.ram_addr    <= '0;
      bus.ram_byteen  <= 4'h0;
      bus.ram_wdata   <= 32'h0;
      bus.jtag_rdata  <= 32'h0;
      bus.av_readdata <= 32'h0;
    end else begin
      if (w_grant) begin
        r_last_grant   <= w_win;
        r_win          <= w_win;
        r_is_wr        <= w_sel_wr;
        bus.ram_addr   <= w_sel_addr;
        bus.ram_byteen <= w_sel_be;
        bus.ram_wdata  <= w_sel_wdata;
      end
      if (w_capture) begin
        if (r_win == SRC_JTAG) begin
          bus.jtag_rdata <= bus.ram_rdata;
        end else begin
          bus.av_readdata <= bus.ram_rdata;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sistema_cpu1_ocimem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_sistema_cpu1_ocimem_arbiter
// Description : Self-checking bench for the OCI memory arbiter. It provides a
//               registered-read RAM and random JTAG and Avalon agents. A
//               transaction-level reference model predicts the outputs every
//               cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sistema_cpu1_ocimem_arbiter;
  localparam int ADDR_W = 8;
  localparam bit J = 1'b0;
  localparam bit A = 1'b1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sistema_cpu1_ocimem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  sistema_cpu1_ocimem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // RAM with one cycle of registered read latency.
  logic [31:0] mem        [256];
  logic [31:0] seed_words [256];
  logic        load_req = 1'b0;
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed_words[i];
    end else if (bus.ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_byteen[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  // Transaction-level reference model.
  bit              m_busy, m_win, m_wr, m_last;
  int              m_cyc, m_len;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]     m_wdata, m_rval, e_jrd, e_ard;
  logic [3:0]      m_be;
  logic [31:0]     shadow [256];
  bit              grant_log [$];

  int j_rate = 0, a_rate = 0;
  bit withdraw_en = 1'b0, dbg_toggle = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_cyc = 0; m_len = 0; m_win = J; m_wr = 0; m_last = A;
    m_addr = '0; m_wdata = 32'h0; m_be = 4'h0; m_rval = 32'h0;
    e_jrd = 32'h0; e_ard = 32'h0;
    grant_log.delete();
  endtask

  task automatic model_step();
    bit jr, ar, w;
    if (!reset_n) return;
    if (m_busy) begin
      if (m_cyc == m_len) begin
        m_busy = 0;
      end else begin
        m_cyc++;
        if (m_cyc == 3) begin
          if (m_win == J) e_jrd = m_rval; else e_ard = m_rval;
        end
      end
    end else begin
      jr = bus.jtag_req;
      ar = bus.av_read || bus.av_write;
      if (jr || ar) begin
        if (jr && ar) w = bus.debugack ? J : ~m_last;
        else          w = jr ? J : A;
        m_busy = 1; m_cyc = 1; m_win = w; m_last = w;
        grant_log.push_back(w);
        if (w == J) begin
          m_wr = bus.jtag_wr; m_addr = bus.jtag_addr; m_wdata = bus.jtag_wdata; m_be = 4'hF;
        end else begin
          m_wr = bus.av_write; m_addr = bus.av_address; m_wdata = bus.av_writedata;
          m_be = bus.av_byteenable;
        end
        m_len  = m_wr ? 1 : 3;
        m_rval = shadow[m_addr];
        if (m_wr)
          for (int b = 0; b < 4; b++)
            if (m_be[b]) shadow[m_addr][8*b +: 8] = m_wdata[8*b +: 8];
      end
    end
  endtask

  task automatic check_all();
    bit fin;
    fin = m_busy && (m_cyc == m_len);
    chk("jtag_done",      32'(bus.jtag_done),      32'(fin && m_win == J));
    chk("av_waitrequest", 32'(bus.av_waitrequest), 32'(!(fin && m_win == A)));
    chk("ram_wren",       32'(bus.ram_wren),       32'(m_busy && m_cyc == 1 && m_wr));
    chk("ram_addr",       32'(bus.ram_addr),       32'(m_addr));
    chk("ram_byteen",     32'(bus.ram_byteen),     32'(m_be));
    chk("ram_wdata",      bus.ram_wdata,           m_wdata);
    chk("jtag_rdata",     bus.jtag_rdata,          e_jrd);
    chk("av_readdata",    bus.av_readdata,         e_ard);
  endtask

  task automatic jtag_issue(input bit wr, input logic [ADDR_W-1:0] addr, input logic [31:0] d);
    bus.jtag_req = 1'b1; bus.jtag_wr = wr; bus.jtag_addr = addr; bus.jtag_wdata = d;
  endtask

  task automatic av_issue(input bit wr, input logic [ADDR_W-1:0] addr, input logic [31:0] d,
                          input logic [3:0] be);
    bus.av_read = !wr; bus.av_write = wr; bus.av_address = addr;
    bus.av_writedata = d; bus.av_byteenable = be;
  endtask

  task automatic drive_agents();
    if (bus.jtag_req && bus.jtag_done) bus.jtag_req = 1'b0;
    else if (bus.jtag_req && withdraw_en && m_busy && m_win == J && $urandom_range(0, 15) == 0)
      bus.jtag_req = 1'b0;
    if (!bus.jtag_req && j_rate > 0 && int'($urandom_range(1, 100)) <= j_rate)
      jtag_issue(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), $urandom);

    if ((bus.av_read || bus.av_write) && !bus.av_waitrequest) begin
      bus.av_read = 1'b0; bus.av_write = 1'b0;
    end else if ((bus.av_read || bus.av_write) && withdraw_en && m_busy && m_win == A &&
                 $urandom_range(0, 15) == 0) begin
      bus.av_read = 1'b0; bus.av_write = 1'b0;
    end
    if (!bus.av_read && !bus.av_write && a_rate > 0 && int'($urandom_range(1, 100)) <= a_rate)
      av_issue(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), $urandom,
               4'($urandom_range(1, 15)));

    if (dbg_toggle && $urandom_range(0, 19) == 0) bus.debugack = ~bus.debugack;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    drive_agents();
  endtask

  task automatic wait_idle(input int limit);
    bit ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      cycle();
      if (!m_busy && !bus.jtag_req && !bus.av_read && !bus.av_write) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
    $fatal(1);
  end

  initial begin
    bit exp_seq [4];
    bit reached;
    int n;
    exp_seq = '{J, A, J, A};
    bus.debugack = 1'b0; bus.jtag_req = 1'b0; bus.jtag_wr = 1'b0;
    bus.jtag_addr = '0; bus.jtag_wdata = 32'h0;
    bus.av_read = 1'b0; bus.av_write = 1'b0; bus.av_address = '0;
    bus.av_writedata = 32'h0; bus.av_byteenable = 4'h0;
    for (int i = 0; i < 256; i++) begin
      seed_words[i] = $urandom;
      shadow[i]     = seed_words[i];
    end
    model_reset();
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
    repeat (3) cycle();
    reset_n = 1'b1;

    // Both requesters held, debugack low: alternation starting with JTAG.
    j_rate = 100; a_rate = 100;
    drive_agents();
    for (int k = 0; k < 40 && grant_log.size() < 4; k++) cycle();
    chk("rr_grant_count", 32'(grant_log.size() >= 4), 32'd1);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      chk($sformatf("rr_grant%0d", k), 32'(grant_log[k]), 32'(exp_seq[k]));
    j_rate = 0; a_rate = 0;
    wait_idle(50);

    // Directed JTAG write, then Avalon write/read and a partial-byte write.
    jtag_issue(1'b1, 8'h10, 32'hDEADBEEF);
    wait_idle(20);
    av_issue(1'b1, 8'h20, 32'h12345678, 4'hF);
    wait_idle(20);
    av_issue(1'b0, 8'h20, 32'h0, 4'hF);
    wait_idle(20);
    chk("av_rd_0x20", bus.av_readdata, 32'h12345678);
    av_issue(1'b1, 8'h20, 32'hAAAABBBB, 4'h3);
    wait_idle(20);
    av_issue(1'b0, 8'h20, 32'h0, 4'hF);
    wait_idle(20);
    chk("av_rd_be3", bus.av_readdata, 32'h1234BBBB);

    // debugack high with both held: only JTAG is served.
    bus.debugack = 1'b1;
    j_rate = 100; a_rate = 100;
    n = grant_log.size();
    drive_agents();
    repeat (30) cycle();
    for (int k = n; k < grant_log.size(); k++)
      chk($sformatf("dbg_grant%0d", k - n), 32'(grant_log[k]), 32'(J));
    bus.debugack = 1'b0;
    n = grant_log.size();
    for (int k = 0; k < 20 && grant_log.size() <= n; k++) cycle();
    chk("av_after_dbg_seen", 32'(grant_log.size() > n), 32'd1);
    if (grant_log.size() > n) chk("av_after_dbg", 32'(grant_log[n]), 32'(A));
    j_rate = 0; a_rate = 0;
    wait_idle(50);

    // Reset pulsed during RWAIT of a JTAG read.
    jtag_issue(1'b0, 8'h20, 32'h0);
    reached = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (m_busy && m_win == J && m_cyc == 2) begin
        reached = 1'b1;
        break;
      end
    end
    chk("rwait_reached", 32'(reached), 32'd1);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
    wait_idle(20);
    chk("jtag_rd_after_rst", bus.jtag_rdata, 32'h1234BBBB);

    // Random traffic with withdrawals and debugack toggling.
    j_rate = 30; a_rate = 30; withdraw_en = 1'b1; dbg_toggle = 1'b1;
    repeat (2000) cycle();
    j_rate = 0; a_rate = 0; withdraw_en = 1'b0; dbg_toggle = 1'b0;
    wait_idle(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
